// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared types, sync bit indices and region helper for the video timing generator
package vtg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vtg_state_e;

  localparam int SYNC_VS = 26;
  localparam int SYNC_HS = 25;
  localparam int SYNC_DE = 24;

  function automatic int region_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// rtl/vtg_axis_counter.sv - one scan axis: position counter with active/sync region decode
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] pos,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = region_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO  = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI  = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (clr) begin
      pos_d = '0;
    end else if (inc) begin
      pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos    = pos_q;
  assign active = (pos_q < ACT_END);
  assign sync   = (pos_q >= SYNC_LO) && (pos_q <= SYNC_HI);
  assign wrap   = inc && (pos_q == LAST);

endmodule

// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - frame sequencer: start/stop FSM, registered sync bundle and frame counting
// Optional frame limit input enabled by VTG_FRAME_LIMIT_EN.
module video_timing_ctrl
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
`ifdef VTG_FRAME_LIMIT_EN
  input  logic [15:0]      frame_limit,
`endif
  output logic [26:24]     Synco,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt
);

  vtg_state_e state_q, state_d;

  logic [26:24]     synco_q, synco_d;
  logic [CNT_W-1:0] h_pos_q, h_pos_d;
  logic [CNT_W-1:0] v_pos_q, v_pos_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
`ifdef VTG_FRAME_LIMIT_EN
  logic [15:0]      limit_q, limit_d;
`endif

  logic             run_d;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_act, h_sy, h_wrap;
  logic             v_act, v_sy, v_wrap;

  // Axis counters run one cycle ahead of the output registers so that every
  // output is a flop while still showing one consistent position.
  vtg_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!run_d),
    .inc    (run_d),
    .pos    (h_cnt),
    .active (h_act),
    .sync   (h_sy),
    .wrap   (h_wrap)
  );

  vtg_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!run_d),
    .inc    (h_wrap),
    .pos    (v_cnt),
    .active (v_act),
    .sync   (v_sy),
    .wrap   (v_wrap)
  );

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q + {15'b0, frame_done_q};
`ifdef VTG_FRAME_LIMIT_EN
    limit_d     = limit_q;
`endif
    // frame_done_q marks the cycle that shows the last position of a frame.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          frame_cnt_d = '0;
`ifdef VTG_FRAME_LIMIT_EN
          limit_d     = frame_limit;
`endif
        end
      end
      RUN: begin
        if (stop) state_d = DRAIN;
`ifdef VTG_FRAME_LIMIT_EN
        if (frame_done_q && (limit_q != 16'd0) && (frame_cnt_q + 16'd1 == limit_q)) state_d = IDLE;
`endif
      end
      DRAIN: begin
        if (start)             state_d = RUN;
        else if (frame_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    run_d = (state_d != IDLE);

    synco_d          = '0;
    synco_d[SYNC_VS] = run_d && v_sy;
    synco_d[SYNC_HS] = run_d && h_sy;
    synco_d[SYNC_DE] = run_d && h_act && v_act;
    h_pos_d          = run_d ? h_cnt : '0;
    v_pos_d          = run_d ? v_cnt : '0;
    busy_d           = run_d;
    frame_done_d     = v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      synco_q      <= '0;
      h_pos_q      <= '0;
      v_pos_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
`ifdef VTG_FRAME_LIMIT_EN
      limit_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      synco_q      <= synco_d;
      h_pos_q      <= h_pos_d;
      v_pos_q      <= v_pos_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
`ifdef VTG_FRAME_LIMIT_EN
      limit_q      <= limit_d;
`endif
    end
  end

  assign Synco      = synco_q;
  assign h_pos      = h_pos_q;
  assign v_pos      = v_pos_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// tb/tb_video_timing_ctrl.sv - self-checking bench for video_timing_ctrl with a frame-position reference model
module tb_video_timing_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int CW = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   frame_limit_v = 16'd0;
  logic [26:24]  Synco;
  logic [CW-1:0] h_pos, v_pos;
  logic          busy, frame_done;
  logic [15:0]   frame_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: a streaming flag, a drain flag and a linear frame index.
  bit          m_act, m_drain;
  int          m_p;
  logic [15:0] m_cnt, m_lim;

  always #5 clk = ~clk;

  video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
`ifdef VTG_FRAME_LIMIT_EN
    .frame_limit(frame_limit_v),
`endif
    .Synco      (Synco),
    .h_pos      (h_pos),
    .v_pos      (v_pos),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt)
  );

  function automatic logic [36:0] exp_vec();
    int h, v;
    logic de, hs, vs;
    h  = m_p % HT;
    v  = m_p / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h < HA + HF + HS);
    vs = (v >= VA + VF) && (v < VA + VF + VS);
    if (!m_act) return {21'b0, m_cnt};
    return {vs, hs, de, CW'(h), CW'(v), 1'b1, (m_p == FT - 1), m_cnt};
  endfunction

  function automatic logic [36:0] obs_vec();
    return {Synco, h_pos, v_pos, busy, frame_done, frame_cnt};
  endfunction

  task automatic model_reset();
    m_act = 0; m_drain = 0; m_p = 0; m_cnt = '0; m_lim = '0;
  endtask

  task automatic model_update(input logic s, input logic t);
    bit last, fin;
    logic [15:0] nxt;
    last = m_act && (m_p == FT - 1);
    fin  = 0;
    nxt  = m_cnt + 16'd1;
    if (!m_act) begin
      if (s) begin
        m_act = 1; m_drain = 0; m_p = 0; m_cnt = '0; m_lim = frame_limit_v;
      end
    end else begin
      if (m_drain) begin
        if (s) m_drain = 0;
        else if (last) fin = 1;
      end else begin
        if (t) m_drain = 1;
        if (last && (m_lim != 16'd0) && (nxt == m_lim)) fin = 1;
      end
      if (last) m_cnt = nxt;
      if (fin) begin
        m_act = 0; m_drain = 0; m_p = 0;
      end else begin
        m_p = (m_p + 1) % FT;
      end
    end
  endtask

  task automatic step(input logic s, input logic t);
    start = s;
    stop  = t;
    @(posedge clk);
    model_update(s, t);
    #1;
  endtask

  task automatic drain_to_idle();
    for (int i = 0; i < 4 * FT && m_act; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs_vec() !== 37'b0) begin
      fails++; $display("FAIL reset_state got=%h exp=0", obs_vec());
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, i[0]);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stream();
    int de_n, hs_n, vs_n, hs_bad, nd, d1, d2;
    de_n = 0; hs_n = 0; vs_n = 0; hs_bad = 0; nd = 0; d1 = -1; d2 = -1;
    for (int i = 1; i <= 2 * FT; i++) begin
      step(i == 1, 1'b0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL stream cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
      if (Synco[24]) de_n++;
      if (Synco[25]) hs_n++;
      if (Synco[26]) vs_n++;
      if (Synco[25] && !(h_pos == 8'd5 || h_pos == 8'd6)) hs_bad++;
      if (frame_done) begin
        nd++;
        if (nd == 1) d1 = i;
        else if (nd == 2) d2 = i;
      end
    end
    step(1'b0, 1'b0);
    tests++;
    if (de_n != 24) begin fails++; $display("FAIL stream_de_count got=%0d exp=24", de_n); end
    tests++;
    if (hs_n != 24 || hs_bad != 0) begin fails++; $display("FAIL stream_hsync got=%0d bad=%0d exp=24 bad=0", hs_n, hs_bad); end
    tests++;
    if (vs_n != 16) begin fails++; $display("FAIL stream_vsync_count got=%0d exp=16", vs_n); end
    tests++;
    if (d1 != 48 || d2 != 96) begin fails++; $display("FAIL stream_done_cycles got=%0d,%0d exp=48,96", d1, d2); end
    tests++;
    if (frame_cnt !== 16'd2) begin fails++; $display("FAIL stream_frame_cnt got=%0d exp=2", frame_cnt); end
    drain_to_idle();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL stream_drain got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_stop_mid();
    int nd, guard, last_h, last_v, idle_done;
    nd = 0; guard = 0; last_h = -1; last_v = -1; idle_done = 0;
    step(1'b1, 1'b0);
    while (!(h_pos == 8'd2 && v_pos == 8'd1) && guard < 2 * FT) begin
      step(1'b0, 1'b0); guard++;
    end
    step(1'b0, 1'b1);
    guard = 0;
    while (busy && guard < 2 * FT) begin
      if (frame_done) nd++;
      last_h = h_pos; last_v = v_pos;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL stop_mid cyc=%0d got=%h exp=%h", guard, obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0); guard++;
    end
    tests++;
    if (nd != 1 || last_h != 7 || last_v != 5) begin
      fails++; $display("FAIL stop_mid_end got done=%0d pos=(%0d,%0d) exp done=1 pos=(7,5)", nd, last_h, last_v);
    end
    tests++;
    if (Synco !== 3'b000 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL stop_mid_idle got=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < FT + 8; i++) begin
      step(1'b0, 1'b0);
      if (frame_done || busy) idle_done++;
    end
    tests++;
    if (idle_done != 0) begin fails++; $display("FAIL stop_mid_no_second got=%0d exp=0", idle_done); end
  endtask

  task automatic test_drain_cancel();
    int gaps;
    logic [15:0] c0;
    gaps = 0;
    step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    c0 = frame_cnt;
    for (int i = 0; i < 2 * FT; i++) begin
      step(1'b0, 1'b0);
      if (!busy) gaps++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL drain_cancel cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (gaps != 0 || frame_cnt !== c0 + 16'd2) begin
      fails++; $display("FAIL drain_cancel_stream got gaps=%0d cnt=%0d exp gaps=0 cnt=%0d", gaps, frame_cnt, c0 + 16'd2);
    end
    drain_to_idle();
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    step(1'b1, 1'b0);
    while (!(v_pos == 8'd2 && h_pos == 8'd3) && guard < 2 * FT) begin
      step(1'b0, 1'b0); guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (obs_vec() !== 37'b0) begin
      fails++; $display("FAIL async_reset got=%h exp=0", obs_vec());
    end
    start = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      tests++;
      if (obs_vec() !== exp_vec() || busy !== 1'b0) begin
        fails++; $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_start_stop_idle();
    int drops;
    drops = 0;
    step(1'b1, 1'b1);
    tests++;
    if (busy !== 1'b1 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL start_stop_idle got=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 2 * FT + 5; i++) begin
      step(1'b0, 1'b0);
      if (!busy) drops++;
    end
    tests++;
    if (drops != 0 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL start_stop_not_latched got drops=%0d vec=%h exp drops=0 vec=%h", drops, obs_vec(), exp_vec());
    end
    drain_to_idle();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_later_stop got busy=%b exp=0", busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    drain_to_idle();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL random_drain got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask

`ifdef VTG_FRAME_LIMIT_EN
  task automatic test_frame_limit();
    int nd, guard;
    nd = 0; guard = 0;
    frame_limit_v = 16'd3;
    step(1'b1, 1'b0);
    frame_limit_v = 16'd0;
    while (busy && guard < 6 * FT) begin
      if (frame_done) nd++;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL frame_limit cyc=%0d got=%h exp=%h", guard, obs_vec(), exp_vec());
      end
      step(1'b0, 1'b0); guard++;
    end
    tests++;
    if (nd != 3 || frame_cnt !== 16'd3 || busy !== 1'b0) begin
      fails++; $display("FAIL frame_limit_end got done=%0d cnt=%0d busy=%b exp done=3 cnt=3 busy=0", nd, frame_cnt, busy);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stop_mid();
    test_drain_cancel();
    test_async_reset();
    test_start_stop_idle();
    test_random();
`ifdef VTG_FRAME_LIMIT_EN
    test_frame_limit();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
